// File: rtl/key_debounce_pkg.sv
// key_pkg: shared constants and helpers for the push-button debouncer.
//   state_t     - FSM state encoding
//   ms_to_cyc   - converts a duration in ms into clk cycles for a given clk rate
//   cnt_width   - counter width able to hold the largest of three cycle counts
package key_pkg;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_DEB_PRESS   = 3'd1,
    ST_HELD        = 3'd2,
    ST_LONG_HELD   = 3'd3,
    ST_DEB_RELEASE = 3'd4
  } state_t;

  function automatic int ms_to_cyc(input int clk_hz, input int ms);
    return (clk_hz / 1000) * ms;
  endfunction

  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m <= 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/key_debounce_if.sv
// key_debounce_if: button input and debounced event outputs.
//   key_n_i      raw active-low button level
//   key_level_o  debounced level, 1 = pressed
//   press_o / release_o / long_press_o / repeat_o  one-cycle event pulses
//   press_cnt_o  8-bit wrapping count of accepted presses
// master: the side owning the button; slave: the debouncer.
interface key_debounce_if;
  logic       key_n_i;
  logic       key_level_o;
  logic       press_o;
  logic       release_o;
  logic       long_press_o;
  logic       repeat_o;
  logic [7:0] press_cnt_o;

  modport master (
    output key_n_i,
    input  key_level_o, press_o, release_o, long_press_o, repeat_o, press_cnt_o
  );

  modport slave (
    input  key_n_i,
    output key_level_o, press_o, release_o, long_press_o, repeat_o, press_cnt_o
  );
endinterface

// File: rtl/key_debounce_sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous bit.
//   clk   sampling clock
//   nRst  asynchronous active-low reset, loads RST_VAL into both flops
//   d_i   asynchronous input
//   q_o   synchronized output
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic nRst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/key_debounce.sv
// key_debounce: push-button debouncer with press/release/long-press events
// and an optional auto-repeat.
//   clk   system clock (rising edge)
//   nRst  asynchronous active-low reset
//   kif   key_debounce_if.slave: raw key in, debounced level/events/count out
// Build option: define KEY_AUTOREPEAT_EN to enable repeat pulses while the key
// stays held past the long-press time; otherwise repeat_o is held at 0.
module key_debounce
  import key_pkg::*;
#(
  parameter int CLK_HZ      = 50000000,
  parameter int DEBOUNCE_MS = 20,
  parameter int LONG_MS     = 1000,
  parameter int REPEAT_MS   = 200
) (
  input  logic           clk,
  input  logic           nRst,
  key_debounce_if.slave  kif
);

  localparam int DEB_CYC  = ms_to_cyc(CLK_HZ, DEBOUNCE_MS);
  localparam int LONG_CYC = ms_to_cyc(CLK_HZ, LONG_MS);
  localparam int REP_CYC  = ms_to_cyc(CLK_HZ, REPEAT_MS);
  localparam int CNT_W    = cnt_width(DEB_CYC, LONG_CYC, REP_CYC);

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYC - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic key_sync;
  logic key_s;

  // Idle button level is high, so the synchronizer resets to 1 to avoid a
  // phantom press right after reset.
  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk  (clk),
    .nRst (nRst),
    .d_i  (kif.key_n_i),
    .q_o  (key_sync)
  );

  assign key_s = ~key_sync;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic             long_flag_q, long_flag_d;
  logic             key_level_q, key_level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             long_q, long_d;
  logic [7:0]       press_cnt_q, press_cnt_d;

`ifdef KEY_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REP_CYC - 1);
  logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
  logic             repeat_q, repeat_d;
`endif

  always_comb begin
    state_d     = state_q;
    deb_cnt_d   = deb_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    long_flag_d = long_flag_q;
    key_level_d = key_level_q;
    press_d     = 1'b0;
    release_d   = 1'b0;
    long_d      = 1'b0;
    press_cnt_d = press_cnt_q;
`ifdef KEY_AUTOREPEAT_EN
    rep_cnt_d   = rep_cnt_q;
    repeat_d    = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (key_s) begin
          state_d   = ST_DEB_PRESS;
          deb_cnt_d = '0;
        end
      end

      ST_DEB_PRESS: begin
        if (!key_s) begin
          state_d = ST_IDLE;
        end else if (deb_cnt_q == DEB_LAST) begin
          state_d     = ST_HELD;
          press_d     = 1'b1;
          key_level_d = 1'b1;
          hold_cnt_d  = '0;
          long_flag_d = 1'b0;
          press_cnt_d = press_cnt_q + 8'd1;
        end else begin
          deb_cnt_d = deb_cnt_q + CNT_ONE;
        end
      end

      ST_HELD: begin
        if (!key_s) begin
          // The cycle that first sees the release still counts as held time;
          // only the debounce window itself is frozen. Saturate at the terminal
          // value so a glitch right at the threshold still yields long_press.
          state_d   = ST_DEB_RELEASE;
          deb_cnt_d = '0;
          if (hold_cnt_q != LONG_LAST) hold_cnt_d = hold_cnt_q + CNT_ONE;
        end else if (hold_cnt_q == LONG_LAST) begin
          state_d     = ST_LONG_HELD;
          long_d      = 1'b1;
          long_flag_d = 1'b1;
`ifdef KEY_AUTOREPEAT_EN
          rep_cnt_d   = '0;
`endif
        end else begin
          hold_cnt_d = hold_cnt_q + CNT_ONE;
        end
      end

      ST_LONG_HELD: begin
        if (!key_s) begin
          state_d   = ST_DEB_RELEASE;
          deb_cnt_d = '0;
        end
`ifdef KEY_AUTOREPEAT_EN
        else if (rep_cnt_q == REP_LAST) begin
          repeat_d  = 1'b1;
          rep_cnt_d = '0;
        end else begin
          rep_cnt_d = rep_cnt_q + CNT_ONE;
        end
`endif
      end

      ST_DEB_RELEASE: begin
        if (key_s) begin
          // Release glitch: resume whichever held state was left.
          state_d = long_flag_q ? ST_LONG_HELD : ST_HELD;
        end else if (deb_cnt_q == DEB_LAST) begin
          state_d     = ST_IDLE;
          release_d   = 1'b1;
          key_level_d = 1'b0;
        end else begin
          deb_cnt_d = deb_cnt_q + CNT_ONE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q     <= ST_IDLE;
      deb_cnt_q   <= '0;
      hold_cnt_q  <= '0;
      long_flag_q <= 1'b0;
      key_level_q <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      long_q      <= 1'b0;
      press_cnt_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      deb_cnt_q   <= deb_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      long_flag_q <= long_flag_d;
      key_level_q <= key_level_d;
      press_q     <= press_d;
      release_q   <= release_d;
      long_q      <= long_d;
      press_cnt_q <= press_cnt_d;
    end
  end

`ifdef KEY_AUTOREPEAT_EN
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      rep_cnt_q <= '0;
      repeat_q  <= 1'b0;
    end else begin
      rep_cnt_q <= rep_cnt_d;
      repeat_q  <= repeat_d;
    end
  end

  assign kif.repeat_o = repeat_q;
`else
  assign kif.repeat_o = 1'b0;
`endif

  assign kif.key_level_o  = key_level_q;
  assign kif.press_o      = press_q;
  assign kif.release_o    = release_q;
  assign kif.long_press_o = long_q;
  assign kif.press_cnt_o  = press_cnt_q;

endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce: directed bench for key_debounce with CLK_HZ=1000,
// DEBOUNCE_MS=4, LONG_MS=20, REPEAT_MS=5 (4/20/5 cycles). Inputs change 1 ns
// after a rising edge ("edge 0"); outputs are sampled 1 ns after each edge.
module tb_key_debounce;

  localparam int CLK_HZ      = 1000;
  localparam int DEBOUNCE_MS = 4;
  localparam int LONG_MS     = 20;
  localparam int REPEAT_MS   = 5;

  logic clk;
  logic nRst;
  int   n_cmp = 0;
  int   n_err = 0;

  key_debounce_if kif();

  key_debounce #(
    .CLK_HZ(CLK_HZ), .DEBOUNCE_MS(DEBOUNCE_MS), .LONG_MS(LONG_MS), .REPEAT_MS(REPEAT_MS)
  ) dut (
    .clk  (clk),
    .nRst (nRst),
    .kif  (kif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    nRst = 1'b0;
    kif.key_n_i = 1'b1;
    tick(3);
    n_cmp++;
    if ({kif.key_level_o, kif.press_o, kif.release_o, kif.long_press_o, kif.repeat_o} !== 5'b0) begin
      n_err++;
      $display("FAIL reset.flags: got %b want 00000", {kif.key_level_o, kif.press_o,
               kif.release_o, kif.long_press_o, kif.repeat_o});
    end
    n_cmp++;
    if (kif.press_cnt_o !== 8'd0) begin
      n_err++;
      $display("FAIL reset.press_cnt: got %0d want 0", kif.press_cnt_o);
    end
    nRst = 1'b1;
    tick(4);
    n_cmp++;
    if ({kif.key_level_o, kif.press_o, kif.press_cnt_o} !== 10'b0) begin
      n_err++;
      $display("FAIL reset.idle_after: got level=%b press=%b cnt=%0d want 0/0/0",
               kif.key_level_o, kif.press_o, kif.press_cnt_o);
    end
    $display("test_reset done");
  endtask

  task automatic test_clean_press;
    kif.key_n_i = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick(1);
      n_cmp++;
      if (kif.press_o !== (i == 7)) begin
        n_err++;
        $display("FAIL clean_press.press edge %0d: got %b want %b", i, kif.press_o, (i == 7));
      end
      n_cmp++;
      if (kif.key_level_o !== (i >= 7)) begin
        n_err++;
        $display("FAIL clean_press.level edge %0d: got %b want %b", i, kif.key_level_o, (i >= 7));
      end
    end
    n_cmp++;
    if (kif.press_cnt_o !== 8'd1) begin
      n_err++;
      $display("FAIL clean_press.cnt: got %0d want 1", kif.press_cnt_o);
    end
    $display("test_clean_press done cnt=%0d", kif.press_cnt_o);
  endtask

  task automatic test_release;
    kif.key_n_i = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick(1);
      n_cmp++;
      if (kif.release_o !== (i == 7)) begin
        n_err++;
        $display("FAIL release.pulse edge %0d: got %b want %b", i, kif.release_o, (i == 7));
      end
      n_cmp++;
      if (kif.key_level_o !== (i < 7)) begin
        n_err++;
        $display("FAIL release.level edge %0d: got %b want %b", i, kif.key_level_o, (i < 7));
      end
    end
    $display("test_release done");
  endtask

  task automatic test_bounce;
    bit pat [14] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1,
                     1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 14; i++) begin
      kif.key_n_i = pat[i];
      tick(1);
      n_cmp++;
      if ({kif.press_o, kif.release_o, kif.key_level_o} !== 3'b000) begin
        n_err++;
        $display("FAIL bounce.quiet step %0d: got press/rel/level=%b want 000", i,
                 {kif.press_o, kif.release_o, kif.key_level_o});
      end
    end
    n_cmp++;
    if (kif.press_cnt_o !== 8'd1) begin
      n_err++;
      $display("FAIL bounce.cnt: got %0d want 1", kif.press_cnt_o);
    end
    $display("test_bounce done");
  endtask

  task automatic test_long_hold;
    logic exp_rep;
    kif.key_n_i = 1'b0;
    tick(7);
    n_cmp++;
    if (kif.press_o !== 1'b1) begin
      n_err++;
      $display("FAIL long_hold.press: got %b want 1", kif.press_o);
    end
    for (int k = 1; k <= 40; k++) begin
      tick(1);
`ifdef KEY_AUTOREPEAT_EN
      exp_rep = (k >= 25) && (k % 5 == 0);
`else
      exp_rep = 1'b0;
`endif
      n_cmp++;
      if (kif.long_press_o !== (k == 20)) begin
        n_err++;
        $display("FAIL long_hold.long edge %0d: got %b want %b", k, kif.long_press_o, (k == 20));
      end
      n_cmp++;
      if (kif.repeat_o !== exp_rep) begin
        n_err++;
        $display("FAIL long_hold.repeat edge %0d: got %b want %b", k, kif.repeat_o, exp_rep);
      end
      n_cmp++;
      if ((int'(kif.press_o) + int'(kif.release_o) + int'(kif.long_press_o) + int'(kif.repeat_o)) > 1) begin
        n_err++;
        $display("FAIL long_hold.exclusive edge %0d: got %b want at most one", k,
                 {kif.press_o, kif.release_o, kif.long_press_o, kif.repeat_o});
      end
    end
    kif.key_n_i = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick(1);
      n_cmp++;
      if ({kif.release_o, kif.long_press_o, kif.repeat_o} !== {(i == 7), 2'b00}) begin
        n_err++;
        $display("FAIL long_hold.release edge %0d: got rel/long/rep=%b want %b", i,
                 {kif.release_o, kif.long_press_o, kif.repeat_o}, {(i == 7), 2'b00});
      end
    end
    $display("test_long_hold done cnt=%0d", kif.press_cnt_o);
  endtask

  task automatic test_release_glitch;
    kif.key_n_i = 1'b0;
    tick(7);
    n_cmp++;
    if (kif.press_o !== 1'b1) begin
      n_err++;
      $display("FAIL glitch.press: got %b want 1", kif.press_o);
    end
    // Key bounces high for two cycles; two debounce cycles are frozen, so
    // long_press moves from 20 to 22 edges after the press.
    for (int k = 1; k <= 30; k++) begin
      if (k == 6) kif.key_n_i = 1'b1;
      if (k == 8) kif.key_n_i = 1'b0;
      tick(1);
      n_cmp++;
      if (kif.long_press_o !== (k == 22)) begin
        n_err++;
        $display("FAIL glitch.long edge %0d: got %b want %b", k, kif.long_press_o, (k == 22));
      end
      n_cmp++;
      if ({kif.release_o, kif.key_level_o} !== 2'b01) begin
        n_err++;
        $display("FAIL glitch.held edge %0d: got rel/level=%b want 01", k,
                 {kif.release_o, kif.key_level_o});
      end
    end
    kif.key_n_i = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick(1);
      n_cmp++;
      if (kif.release_o !== (i == 7)) begin
        n_err++;
        $display("FAIL glitch.release edge %0d: got %b want %b", i, kif.release_o, (i == 7));
      end
    end
    n_cmp++;
    if (kif.press_cnt_o !== 8'd3) begin
      n_err++;
      $display("FAIL glitch.cnt: got %0d want 3", kif.press_cnt_o);
    end
    $display("test_release_glitch done");
  endtask

  task automatic test_wrap;
    logic [7:0] exp_cnt;
    exp_cnt = 8'd3;
    for (int n = 0; n < 256; n++) begin
      kif.key_n_i = 1'b0;
      tick(7);
      exp_cnt = exp_cnt + 8'd1;
      n_cmp++;
      if ({kif.press_o, kif.press_cnt_o} !== {1'b1, exp_cnt}) begin
        n_err++;
        $display("FAIL wrap.press iter %0d: got press=%b cnt=%0d want 1/%0d", n,
                 kif.press_o, kif.press_cnt_o, exp_cnt);
      end
      kif.key_n_i = 1'b1;
      tick(8);
    end
    n_cmp++;
    if (kif.press_cnt_o !== 8'd3) begin
      n_err++;
      $display("FAIL wrap.final: got %0d want 3", kif.press_cnt_o);
    end
    $display("test_wrap done cnt=%0d", kif.press_cnt_o);
  endtask

  task automatic test_reset_mid_hold;
    kif.key_n_i = 1'b0;
    tick(7 + 25);
    nRst = 1'b0;
    #1;
    n_cmp++;
    if ({kif.key_level_o, kif.press_o, kif.release_o, kif.long_press_o, kif.repeat_o,
         kif.press_cnt_o} !== 13'b0) begin
      n_err++;
      $display("FAIL rst_mid.async: got flags=%b cnt=%0d want all 0",
               {kif.key_level_o, kif.press_o, kif.release_o, kif.long_press_o, kif.repeat_o},
               kif.press_cnt_o);
    end
    for (int i = 1; i <= 3; i++) begin
      tick(1);
      n_cmp++;
      if ({kif.release_o, kif.key_level_o} !== 2'b00) begin
        n_err++;
        $display("FAIL rst_mid.hold edge %0d: got rel/level=%b want 00", i,
                 {kif.release_o, kif.key_level_o});
      end
    end
    nRst = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick(1);
      n_cmp++;
      if ({kif.press_o, kif.release_o, kif.key_level_o} !== {(i == 7), 1'b0, (i >= 7)}) begin
        n_err++;
        $display("FAIL rst_mid.repress edge %0d: got press/rel/level=%b want %b", i,
                 {kif.press_o, kif.release_o, kif.key_level_o}, {(i == 7), 1'b0, (i >= 7)});
      end
    end
    n_cmp++;
    if (kif.press_cnt_o !== 8'd1) begin
      n_err++;
      $display("FAIL rst_mid.cnt: got %0d want 1", kif.press_cnt_o);
    end
    $display("test_reset_mid_hold done");
  endtask

  initial begin
    nRst = 1'b0;
    kif.key_n_i = 1'b1;
    test_reset();
    test_clean_press();
    test_release();
    tick(3);
    test_bounce();
    test_long_hold();
    tick(3);
    test_release_glitch();
    tick(3);
    test_wrap();
    tick(3);
    test_reset_mid_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
